pc_redirect_unit: RTL and testbench
===================================

# pc_redirect_unit

Fetch-stage program-counter owner for the five-stage RISC-V pipeline. It consumes the execute-stage branch decision (`PCSrcE`) and the candidate targets, and holds the PC register. It produces the fetch PC and the decode/execute flush requests. It is the receiving end of the branch-resolution interface.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; `rst==0` resets).
- `PCSrcE`  in  2  redirect select: 00 sequential, 01 branch/JAL target, 10 JALR target, 11 reserved.
- `PCTargetE`  in  32  PC-relative target (branch/JAL).
- `ALUResultE`  in  32  register-relative target (JALR).
- `stallF`  in  1  hold fetch PC (hazard unit).
- `flushReqE`  in  1  external execute-bubble request (load-use).
- `PCF`  out  32  current fetch PC.
- `PCPlus4F`  out  32  `PCF + 4`, combinational.
- `validF`  out  1  fetch slot holds a real instruction.
- `flushD`  out  1  clear IF/ID register this cycle.
- `flushE`  out  1  clear ID/EX register this cycle.
- `misalignF`  out  1  sticky misaligned-redirect flag (see Configuration).
- `misalignPC`  out  32  first offending target (see Configuration).

## Operation
- States: BOOT, RUN.
- Reset (`rst==0` at edge): `PCF=RESET_PC`, state BOOT, `misalignF=0`, `misalignPC=0`.
- BOOT (exactly one cycle after reset release):
  - `validF=0`, `flushD=1`, `flushE=1`.
  - `PCSrcE` and `stallF` ignored; `PCF` held.
  - Next state is RUN.
- RUN, next-PC priority:
  1. `PCSrcE==01` → `PCTargetE`.
  2. `PCSrcE==10` → `{ALUResultE[31:1],1'b0}`.
  3. `stallF==1` → `PCF`.
  4. Otherwise → `PCF+4`.
- Redirect overrides stall: a taken redirect in the same cycle as `stallF` still loads the target.
- `PCSrcE==11` is treated as 00: no redirect, no flush.
- RUN outputs: `validF=1`.
  - `taken = (PCSrcE==01)|(PCSrcE==10)`.
  - `flushD = taken`.
  - `flushE = taken | flushReqE`.
- Arithmetic: `PCF+4` is 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- `rst` low in any state, including mid-redirect, wins over all other inputs.

## Timing
- Redirect latency: `PCSrcE` valid in cycle N → `PCF` = target in cycle N+1.
- `flushD`/`flushE` are combinational in cycle N, so the wrong-path instructions are squashed at the N→N+1 edge.
- `stallF` held k cycles → `PCF` constant for k cycles, then increments.
- First valid fetch of `RESET_PC` is the second cycle after `rst` returns high.
- Output values while `rst==0` (after the edge): `PCF=RESET_PC`, `validF=0`, `flushD=flushE=1`, `misalignF=0`.

## Configuration
- Macro `MISALIGN_CHECK_EN`.
- Defined:
  - On a taken redirect whose final target (after JALR bit-0 clear) has bit 1 set, the redirect still executes.
  - `misalignF` sets the next cycle and stays set until reset.
  - `misalignPC` captures the first such target only; later misaligned redirects leave it unchanged.
- Undefined: `misalignF` and `misalignPC` are tied to 0 and no checking logic is synthesised.

## Test plan
- Reset then release with `RESET_PC=32'h100` → one BOOT cycle with `validF=0` and `flushD=flushE=1`, then `PCF` runs 0x100, 0x104, 0x108.
- RUN at `PCF=0x20`, `PCSrcE=01`, `PCTargetE=0x80` → `flushD=flushE=1` in that cycle; next `PCF=0x80`, then 0x84.
- `PCSrcE=10`, `ALUResultE=0x0000_0207` → next `PCF=0x206`. With `MISALIGN_CHECK_EN`, `misalignF=1` and `misalignPC=0x206`; a later target 0x302 leaves `misalignPC=0x206`.
- `stallF=1` for 3 cycles at `PCF=0x40` → `PCF` stays 0x40 for 3 cycles; with `PCSrcE=01` and target 0x10 during the stall → next `PCF=0x10`.
- `flushReqE=1` with `PCSrcE=00` → `flushE=1`, `flushD=0`, PC advances normally; `PCSrcE=11` → no flush, PC+4.
- `rst` low in the same cycle as a taken redirect → `PCF=RESET_PC`, BOOT re-entered; `PCF` at 0xFFFF_FFFC with no stall → next `PCF=0x0`.

Source files
------------

// File: rtl/pc_redirect_unit_if.sv
// rtl/pc_redirect_unit_if.sv - branch-resolution bundle from execute to the fetch PC owner
// Carries the redirect select and both candidate targets.
interface pc_redirect_unit_if;
  logic [1:0]  PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] ALUResultE;

  modport master (
    output PCSrcE,
    output PCTargetE,
    output ALUResultE
  );

  modport slave (
    input PCSrcE,
    input PCTargetE,
    input ALUResultE
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - fetch PC register with branch/JALR redirect and pipeline flush requests
// Optional misaligned-target capture is built when MISALIGN_CHECK_EN is defined.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  pc_redirect_unit_if.slave       br,
  input  logic                    stallF,
  input  logic                    flushReqE,
  output logic [31:0]             PCF,
  output logic [31:0]             PCPlus4F,
  output logic                    validF,
  output logic                    flushD,
  output logic                    flushE,
  output logic                    misalignF,
  output logic [31:0]             misalignPC
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        taken;
  logic [31:0] target;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    validF   = 1'b0;
    flushD   = 1'b1;
    flushE   = 1'b1;
    taken    = 1'b0;
    PCPlus4F = pc_q + 32'd4;
    // JALR targets drop bit 0; select 11 falls through as sequential
    target   = (br.PCSrcE == 2'b10) ? (br.ALUResultE & ~32'd1) : br.PCTargetE;

    if (state_q == BOOT) begin
      state_d = RUN;
    end else begin
      validF = 1'b1;
      taken  = (br.PCSrcE == 2'b01) || (br.PCSrcE == 2'b10);
      flushD = taken;
      flushE = taken || flushReqE;
      if (taken) begin
        pc_d = target;
      end else if (!stallF) begin
        pc_d = PCPlus4F;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign PCF = pc_q;

`ifdef MISALIGN_CHECK_EN
  logic        misalign_q, misalign_d;
  logic [31:0] misalign_pc_q, misalign_pc_d;

  // Only the first offending target is recorded; the flag is sticky until reset
  always_comb begin
    misalign_d    = misalign_q;
    misalign_pc_d = misalign_pc_q;
    if (taken && target[1]) begin
      misalign_d = 1'b1;
      if (!misalign_q) begin
        misalign_pc_d = target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      misalign_q    <= 1'b0;
      misalign_pc_q <= 32'h0000_0000;
    end else begin
      misalign_q    <= misalign_d;
      misalign_pc_q <= misalign_pc_d;
    end
  end

  assign misalignF  = misalign_q;
  assign misalignPC = misalign_pc_q;
`else
  assign misalignF  = 1'b0;
  assign misalignPC = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - scoreboard bench for pc_redirect_unit (MISALIGN_CHECK_EN aware)
module tb_pc_redirect_unit;

`ifdef MISALIGN_CHECK_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        v;
    logic        fd;
    logic        fe;
    logic        mf;
    logic [31:0] mpc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF;
  logic        flushReqE;
  logic [31:0] PCF, PCPlus4F, misalignPC;
  logic        validF, flushD, flushE, misalignF;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  pc_redirect_unit_if br ();

  pc_redirect_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk       (clk),
    .rst       (rst),
    .br        (br.slave),
    .stallF    (stallF),
    .flushReqE (flushReqE),
    .PCF       (PCF),
    .PCPlus4F  (PCPlus4F),
    .validF    (validF),
    .flushD    (flushD),
    .flushE    (flushE),
    .misalignF (misalignF),
    .misalignPC(misalignPC)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, record the outputs expected during that cycle, then advance
  task automatic step(input string name, input logic r, input logic [1:0] src,
                      input logic [31:0] tgt, input logic [31:0] alu, input logic st,
                      input logic frq, input logic [31:0] epc, input logic ev,
                      input logic efd, input logic efe, input logic emf,
                      input logic [31:0] empc);
    exp_t e;
    rst = r; br.PCSrcE = src; br.PCTargetE = tgt; br.ALUResultE = alu;
    stallF = st; flushReqE = frq;
    e.name = name; e.pc = epc; e.v = ev; e.fd = efd; e.fe = efe;
    e.mf = emf & MEN; e.mpc = MEN ? empc : 32'h0;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle, so compare mid-cycle whenever work is pending
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      if (PCF !== e.pc || PCPlus4F !== e.pc + 32'd4 || validF !== e.v || flushD !== e.fd ||
          flushE !== e.fe || misalignF !== e.mf || misalignPC !== e.mpc) begin
        fails++;
        $display("FAIL %s: got pc=%h pc4=%h v=%b fd=%b fe=%b mf=%b mpc=%h, want pc=%h pc4=%h v=%b fd=%b fe=%b mf=%b mpc=%h",
                 e.name, PCF, PCPlus4F, validF, flushD, flushE, misalignF, misalignPC,
                 e.pc, e.pc + 32'd4, e.v, e.fd, e.fe, e.mf, e.mpc);
      end
    end
  end

  initial begin
    int budget;
    rst = 1'b0; stallF = 1'b0; flushReqE = 1'b0;
    br.PCSrcE = 2'b00; br.PCTargetE = 32'h0; br.ALUResultE = 32'h0;
    @(posedge clk);
    #1;
    //    name            rst src    tgt           alu           st   frq  pc            v fd fe mf mpc
    step("reset_hold",    0, 2'b00, 32'h0,        32'h0,        0,   0,   32'h100,      0, 1, 1, 0, 32'h0);
    step("boot_ignores",  1, 2'b01, 32'h500,      32'h0,        1,   0,   32'h100,      0, 1, 1, 0, 32'h0);
    step("run_first",     1, 2'b00, 32'h0,        32'h0,        0,   0,   32'h100,      1, 0, 0, 0, 32'h0);
    step("seq_104",       1, 2'b00, 32'h0,        32'h0,        0,   0,   32'h104,      1, 0, 0, 0, 32'h0);
    step("br_to_20",      1, 2'b01, 32'h20,       32'h0,        0,   0,   32'h108,      1, 1, 1, 0, 32'h0);
    step("br_to_80",      1, 2'b01, 32'h80,       32'h0,        0,   0,   32'h20,       1, 1, 1, 0, 32'h0);
    step("at_80",         1, 2'b00, 32'h0,        32'h0,        0,   0,   32'h80,       1, 0, 0, 0, 32'h0);
    step("jalr_207",      1, 2'b10, 32'h0,        32'h207,      0,   0,   32'h84,       1, 1, 1, 0, 32'h0);
    step("at_206",        1, 2'b01, 32'h40,       32'h0,        0,   0,   32'h206,      1, 1, 1, 1, 32'h206);
    step("stall_1",       1, 2'b00, 32'h0,        32'h0,        1,   0,   32'h40,       1, 0, 0, 1, 32'h206);
    step("stall_2",       1, 2'b00, 32'h0,        32'h0,        1,   0,   32'h40,       1, 0, 0, 1, 32'h206);
    step("stall_redir",   1, 2'b01, 32'h10,       32'h0,        1,   0,   32'h40,       1, 1, 1, 1, 32'h206);
    step("jalr_302",      1, 2'b10, 32'h0,        32'h302,      0,   0,   32'h10,       1, 1, 1, 1, 32'h206);
    step("flush_req",     1, 2'b00, 32'h0,        32'h0,        0,   1,   32'h302,      1, 0, 1, 1, 32'h206);
    step("src_11",        1, 2'b11, 32'h900,      32'h901,      0,   0,   32'h306,      1, 0, 0, 1, 32'h206);
    step("br_to_top",     1, 2'b01, 32'hFFFF_FFFC, 32'h0,       0,   0,   32'h30A,      1, 1, 1, 1, 32'h206);
    step("wrap",          1, 2'b00, 32'h0,        32'h0,        0,   0,   32'hFFFF_FFFC, 1, 0, 0, 1, 32'h206);
    step("rst_on_redir",  0, 2'b01, 32'h80,       32'h0,        0,   0,   32'h0,        1, 1, 1, 1, 32'h206);
    step("reboot",        1, 2'b10, 32'h0,        32'h0,        0,   1,   32'h100,      0, 1, 1, 0, 32'h0);
    step("rerun_100",     1, 2'b00, 32'h0,        32'h0,        0,   0,   32'h100,      1, 0, 0, 0, 32'h0);
    step("rerun_104",     1, 2'b00, 32'h0,        32'h0,        0,   0,   32'h104,      1, 0, 0, 0, 32'h0);
    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
